// File: rtl/soric_efpga_arbiter_if.sv
// soric_efpga_arbiter_if: core request ports and eFPGA fabric bus shared by the arbiter
interface soric_efpga_arbiter_if #(
   parameter int DW = 32,
   parameter int OPW = 2,
   parameter int DLYW = 2
);
   logic req_1_i, req_2_i;
   logic [DW-1:0] op_a_1_i, op_a_2_i, op_b_1_i, op_b_2_i;
   logic [OPW-1:0] opr_1_i, opr_2_i;
   logic [DLYW-1:0] dly_1_i, dly_2_i;
   logic done_1_o, done_2_o, err_1_o, err_2_o;
   logic [DW-1:0] res_a_o, res_b_o, res_c_o;
   logic efpga_en_o;
   logic [DW-1:0] efpga_op_a_o, efpga_op_b_o;
   logic [OPW-1:0] efpga_opr_o;
   logic [DLYW-1:0] efpga_dly_o;
   logic [DW-1:0] efpga_res_a_i, efpga_res_b_i, efpga_res_c_i;
   logic efpga_done_i;
   logic [1:0] grant_o;
   logic busy_o;
   modport slave (
      input req_1_i, req_2_i, op_a_1_i, op_a_2_i, op_b_1_i, op_b_2_i, opr_1_i, opr_2_i,
            dly_1_i, dly_2_i, efpga_res_a_i, efpga_res_b_i, efpga_res_c_i, efpga_done_i,
      output done_1_o, done_2_o, err_1_o, err_2_o, res_a_o, res_b_o, res_c_o, efpga_en_o,
             efpga_op_a_o, efpga_op_b_o, efpga_opr_o, efpga_dly_o, grant_o, busy_o
   );
   modport master (
      output req_1_i, req_2_i, op_a_1_i, op_a_2_i, op_b_1_i, op_b_2_i, opr_1_i, opr_2_i,
             dly_1_i, dly_2_i, efpga_res_a_i, efpga_res_b_i, efpga_res_c_i, efpga_done_i,
      input done_1_o, done_2_o, err_1_o, err_2_o, res_a_o, res_b_o, res_c_o, efpga_en_o,
            efpga_op_a_o, efpga_op_b_o, efpga_opr_o, efpga_dly_o, grant_o, busy_o
   );
endinterface

// File: rtl/soric_efpga_arbiter.sv
// soric_efpga_arbiter: round-robin sharing of one eFPGA custom-instruction slot between two cores
module soric_efpga_arbiter #(
   parameter int DW = 32,
   parameter int OPW = 2,
   parameter int DLYW = 2,
   parameter int TIMEOUT = 1023
) (
   input logic wb_clk_i,
   input logic wb_rst_ni,
   soric_efpga_arbiter_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + (1 << DLYW));
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state;
   logic last_grant, pick2, fixed_mode, cap, abort;
   logic [CW-1:0] count;
   // last_grant = 1 means core2 was served last, so core1 wins a tie
   always_comb begin
      pick2 = bus.req_2_i & (~bus.req_1_i | ~last_grant);
      fixed_mode = bus.efpga_dly_o != '0;
      abort = ~fixed_mode & ~bus.efpga_done_i & (count == CW'(TIMEOUT - 1));
      cap = fixed_mode ? (count + CW'(1)) == CW'(bus.efpga_dly_o) : bus.efpga_done_i | abort;
   end
   assign bus.busy_o = state != IDLE;
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         state <= IDLE;
         last_grant <= 1'b1;
         count <= '0;
         bus.grant_o <= '0;
         bus.efpga_en_o <= 1'b0;
         bus.efpga_op_a_o <= '0;
         bus.efpga_op_b_o <= '0;
         bus.efpga_opr_o <= '0;
         bus.efpga_dly_o <= '0;
         bus.done_1_o <= 1'b0;
         bus.done_2_o <= 1'b0;
         bus.err_1_o <= 1'b0;
         bus.err_2_o <= 1'b0;
         bus.res_a_o <= '0;
         bus.res_b_o <= '0;
         bus.res_c_o <= '0;
      end else
         case (state)
            IDLE: if (bus.req_1_i | bus.req_2_i) begin
               state <= ISSUE;
               bus.efpga_en_o <= 1'b1;
               bus.grant_o <= pick2 ? 2'b10 : 2'b01;
               last_grant <= pick2;
               bus.efpga_op_a_o <= pick2 ? bus.op_a_2_i : bus.op_a_1_i;
               bus.efpga_op_b_o <= pick2 ? bus.op_b_2_i : bus.op_b_1_i;
               bus.efpga_opr_o <= pick2 ? bus.opr_2_i : bus.opr_1_i;
               bus.efpga_dly_o <= pick2 ? bus.dly_2_i : bus.dly_1_i;
            end
            ISSUE: begin
               state <= WAIT;
               bus.efpga_en_o <= 1'b0;
               count <= '0;
            end
            WAIT: if (cap) begin
               state <= RESP;
               bus.res_a_o <= abort ? '0 : bus.efpga_res_a_i;
               bus.res_b_o <= abort ? '0 : bus.efpga_res_b_i;
               bus.res_c_o <= abort ? '0 : bus.efpga_res_c_i;
               bus.done_1_o <= bus.grant_o[0];
               bus.done_2_o <= bus.grant_o[1];
               bus.err_1_o <= abort & bus.grant_o[0];
               bus.err_2_o <= abort & bus.grant_o[1];
            end else
               count <= count + CW'(1);
            RESP: begin
               state <= IDLE;
               bus.grant_o <= '0;
               bus.done_1_o <= 1'b0;
               bus.done_2_o <= 1'b0;
               bus.err_1_o <= 1'b0;
               bus.err_2_o <= 1'b0;
            end
         endcase
endmodule

// File: tb/tb_soric_efpga_arbiter.sv
// tb_soric_efpga_arbiter: scoreboard bench with a fabric model and a queue-based arbitration model
module tb_soric_efpga_arbiter;
   localparam int DW = 32, OPW = 2, DLYW = 2, TO = 8;
   typedef struct {
      int core;
      logic [DW-1:0] a, b;
      logic [OPW-1:0] opr;
      logic [DLYW-1:0] dly;
      int pd;
      bit spur;
   } txn_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int cyc = 0, checks = 0, errors = 0, last = 2, en_cyc = 0;
   logic [DW-1:0] held_a = '0, held_b = '0, held_c = '0;
   txn_t cq1[$], cq2[$], exp_q[$], fab_q[$];
   int order[$];
   bit fab_act = 0;
   soric_efpga_arbiter_if #(.DW(DW), .OPW(OPW), .DLYW(DLYW)) bus();
   soric_efpga_arbiter #(.DW(DW), .OPW(OPW), .DLYW(DLYW), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk),
      .wb_rst_ni(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // fabric behaviour: A+B, A^B, A-B+{opr,dly}
   function automatic logic [3*DW-1:0] fab_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [OPW-1:0] opr, logic [DLYW-1:0] dly);
      return {a + b, a ^ b, a - b + DW'({opr, dly})};
   endfunction
   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask
   function automatic txn_t junk();
      txn_t t;
      t.core = 0;
      t.a = $urandom;
      t.b = $urandom;
      t.opr = OPW'($urandom);
      t.dly = DLYW'($urandom);
      t.pd = 0;
      t.spur = 0;
      return t;
   endfunction
   task automatic apply(int c, txn_t t);
      if (c == 1) begin
         bus.op_a_1_i = t.a; bus.op_b_1_i = t.b; bus.opr_1_i = t.opr; bus.dly_1_i = t.dly;
      end else begin
         bus.op_a_2_i = t.a; bus.op_b_2_i = t.b; bus.opr_2_i = t.opr; bus.dly_2_i = t.dly;
      end
   endtask
   task automatic add(int c, logic [DW-1:0] a, logic [DW-1:0] b, logic [OPW-1:0] opr, logic [DLYW-1:0] dly, int pd, bit spur);
      txn_t t = '{c, a, b, opr, dly, pd, spur};
      if (c == 1) cq1.push_back(t); else cq2.push_back(t);
   endtask
   task automatic add_rand(int c);
      logic [DLYW-1:0] d = DLYW'($urandom);
      add(c, $urandom, $urandom, OPW'($urandom), d, d == 0 ? int'($urandom_range(0, TO)) : 0, 1'($urandom));
   endtask
   // round-robin model: each core's queue length is how many back-to-back requests it holds
   task automatic plan();
      int p1 = cq1.size(), p2 = cq2.size(), i1 = 0, i2 = 0, c;
      order.delete();
      while (p1 + p2 > 0) begin
         c = (p1 > 0 && p2 > 0) ? (last == 1 ? 2 : 1) : (p1 > 0 ? 1 : 2);
         order.push_back(c);
         if (c == 1) begin
            exp_q.push_back(cq1[i1]); fab_q.push_back(cq1[i1]); i1++; p1--;
         end else begin
            exp_q.push_back(cq2[i2]); fab_q.push_back(cq2[i2]); i2++; p2--;
         end
         last = c;
      end
   endtask
   task automatic run();
      int rem1, rem2, ei = 0, dn = 0, total, exp_en, c;
      plan();
      rem1 = cq1.size();
      rem2 = cq2.size();
      total = rem1 + rem2;
      @(negedge clk);
      if (rem1 > 0) apply(1, cq1[0]);
      if (rem2 > 0) apply(2, cq2[0]);
      bus.req_1_i = rem1 > 0;
      bus.req_2_i = rem2 > 0;
      exp_en = cyc + 1;
      for (int w = 0; w < 60 * total && dn < total; w++) begin
         @(negedge clk);
         if (bus.efpga_en_o && ei < total) begin
            chk("issue_cycle", cyc, exp_en);
            c = order[ei];
            ei++;
            if (c == 1) begin
               cq1.delete(0); apply(1, cq1.size() > 0 ? cq1[0] : junk());
            end else begin
               cq2.delete(0); apply(2, cq2.size() > 0 ? cq2[0] : junk());
            end
         end
         if (bus.done_1_o && rem1 > 0) begin
            dn++; exp_en = cyc + 2; rem1--;
            if (rem1 == 0) bus.req_1_i = 1'b0;
         end
         if (bus.done_2_o && rem2 > 0) begin
            dn++; exp_en = cyc + 2; rem2--;
            if (rem2 == 0) bus.req_2_i = 1'b0;
         end
      end
      if (dn < total) begin
         checks++; errors++;
         $display("FAIL run_timeout: got %0d responses, expected %0d", dn, total);
         bus.req_1_i = 1'b0; bus.req_2_i = 1'b0; cq1.delete(); cq2.delete();
      end
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_ctrl", 32'({bus.busy_o, bus.grant_o, bus.efpga_en_o, bus.done_1_o, bus.done_2_o, bus.err_1_o, bus.err_2_o}), 0);
      chk("rst_res", bus.res_a_o | bus.res_b_o | bus.res_c_o, 0);
      chk("rst_efpga", bus.efpga_op_a_o | bus.efpga_op_b_o | 32'({bus.efpga_opr_o, bus.efpga_dly_o}), 0);
      exp_q.delete(); fab_q.delete(); cq1.delete(); cq2.delete();
      fab_act = 0; last = 2; held_a = '0; held_b = '0; held_c = '0;
      bus.req_1_i = 1'b0; bus.req_2_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask
   // fabric: correct results only in the capture cycle, junk otherwise
   initial begin
      txn_t ft;
      int k = 0;
      logic cap;
      bus.efpga_done_i = 1'b0;
      {bus.efpga_res_a_i, bus.efpga_res_b_i, bus.efpga_res_c_i} = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.efpga_en_o && fab_q.size() != 0) begin
            ft = fab_q.pop_front(); k = 0; fab_act = 1;
         end else if (fab_act) begin
            k++;
            if (k > TO + 4) fab_act = 0;
         end
         bus.efpga_done_i = fab_act && ((ft.dly == 0 && ft.pd != 0 && k == ft.pd) || (ft.spur && k == (ft.dly == 0 ? 0 : 1)));
         cap = fab_act && (ft.dly != 0 ? k == int'(ft.dly) : (ft.pd != 0 && k == ft.pd));
         {bus.efpga_res_a_i, bus.efpga_res_b_i, bus.efpga_res_c_i} = cap ?
            fab_f(bus.efpga_op_a_o, bus.efpga_op_b_o, bus.efpga_opr_o, bus.efpga_dly_o) : {$urandom, $urandom, $urandom};
      end
   end
   // monitor
   initial begin
      txn_t e;
      logic [3*DW-1:0] r;
      bit ab, prev_en = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.efpga_en_o) begin
               chk("en_pulse", 32'(prev_en), 0);
               en_cyc = cyc;
            end
            prev_en = bus.efpga_en_o;
            if (bus.done_1_o || bus.done_2_o) begin
               chk("done_onehot", 32'(bus.done_1_o & bus.done_2_o), 0);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got done %b%b, expected none", bus.done_2_o, bus.done_1_o);
               end else begin
                  e = exp_q.pop_front();
                  ab = e.dly == 0 && e.pd == 0;
                  r = ab ? '0 : fab_f(e.a, e.b, e.opr, e.dly);
                  chk("done_core", bus.done_2_o ? 2 : 1, e.core);
                  chk("grant", 32'(bus.grant_o), e.core);
                  chk("busy", 32'(bus.busy_o), 1);
                  chk("res_a", bus.res_a_o, r[3*DW-1 -: DW]);
                  chk("res_b", bus.res_b_o, r[2*DW-1 -: DW]);
                  chk("res_c", bus.res_c_o, r[DW-1:0]);
                  chk("err", 32'({bus.err_2_o, bus.err_1_o}), ab ? e.core : 0);
                  chk("latency", cyc - en_cyc, e.dly != 0 ? int'(e.dly) + 1 : (e.pd != 0 ? e.pd + 1 : TO + 1));
                  {held_a, held_b, held_c} = r;
               end
            end else begin
               chk("res_hold", 32'({bus.res_a_o, bus.res_b_o, bus.res_c_o} != {held_a, held_b, held_c}), 0);
               chk("err_idle", 32'({bus.err_2_o, bus.err_1_o}), 0);
            end
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      int n1, n2;
      bus.req_1_i = 1'b0; bus.req_2_i = 1'b0;
      apply(1, junk()); apply(2, junk());
      do_reset();
      add(1, 32'h11, 32'h22, 2'd1, 2'd2, 0, 1);
      run();
      do_reset();
      add_rand(1); add_rand(2);
      run();
      add(1, 32'hCAFE, 32'h0, 2'd0, 2'd0, 5, 1);
      run();
      add(1, $urandom, $urandom, 2'd3, 2'd0, 0, 0);
      add(1, $urandom, $urandom, 2'd2, 2'd1, 0, 0);
      run();
      add(2, $urandom, $urandom, 2'd1, 2'd0, TO, 0);
      run();
      do_reset();
      repeat (2) add_rand(1);
      repeat (2) add_rand(2);
      run();
      add(1, $urandom, $urandom, 2'd0, 2'd0, 0, 0);
      plan();
      @(negedge clk);
      apply(1, cq1[0]);
      bus.req_1_i = 1'b1;
      for (int w = 0; w < 5 && !bus.efpga_en_o; w++) @(negedge clk);
      chk("mid_issue", 32'(bus.efpga_en_o), 1);
      repeat (3) @(negedge clk);
      chk("mid_busy", 32'(bus.busy_o), 1);
      do_reset();
      add_rand(1); add_rand(2);
      run();
      for (int i = 0; i < 12; i++) begin
         n1 = $urandom_range(0, 2);
         n2 = $urandom_range(0, 2);
         if (n1 + n2 == 0) n1 = 1;
         repeat (n1) add_rand(1);
         repeat (n2) add_rand(2);
         run();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
